mem_arbiter: RTL and testbench

Parametrised N-port memory arbiter that lets several RV32I requesters (instruction fetch, data load/store, later DMA or debug) share one fixed-latency memory. It sits between the core's memory ports and a single unified memory, granting at most one request per cycle and routing each response back to its originator. It replaces the dedicated one-memory-per-port wiring in the top-level integration.

---
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bus bundle between the requester ports, the arbiter and the shared memory.
//
// Requester side (per port, packed over NUM_PORTS):
//   req_i, addr_i, wr_i, wr_data_i, byte_en_i, zero_extnd_i  -> arbiter
//   gnt_o (one-hot), rvalid_o (one-hot), rd_data_o (shared) <- arbiter
// Memory side:
//   mem_req_o, mem_addr_o, mem_wr_o, mem_wr_data_o,
//   mem_byte_en_o, mem_zero_extnd_o                          <- arbiter
//   mem_ready_i, mem_rd_data_i                               -> arbiter
//
// Modports:
//   slave  : the arbiter's view
//   master : the view of whatever drives requests and models the memory
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]             req_i;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_i;
    logic [NUM_PORTS-1:0]             wr_i;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wr_data_i;
    logic [NUM_PORTS-1:0][1:0]        byte_en_i;
    logic [NUM_PORTS-1:0]             zero_extnd_i;
    logic [NUM_PORTS-1:0]             gnt_o;
    logic [NUM_PORTS-1:0]             rvalid_o;
    logic [DATA_W-1:0]                rd_data_o;

    logic                             mem_req_o;
    logic                             mem_ready_i;
    logic [ADDR_W-1:0]                mem_addr_o;
    logic                             mem_wr_o;
    logic [DATA_W-1:0]                mem_wr_data_o;
    logic [1:0]                       mem_byte_en_o;
    logic                             mem_zero_extnd_o;
    logic [DATA_W-1:0]                mem_rd_data_i;

    modport slave (
        input  req_i, addr_i, wr_i, wr_data_i, byte_en_i, zero_extnd_i,
        input  mem_ready_i, mem_rd_data_i,
        output gnt_o, rvalid_o, rd_data_o,
        output mem_req_o, mem_addr_o, mem_wr_o, mem_wr_data_o,
        output mem_byte_en_o, mem_zero_extnd_o
    );

    modport master (
        output req_i, addr_i, wr_i, wr_data_i, byte_en_i, zero_extnd_i,
        output mem_ready_i, mem_rd_data_i,
        input  gnt_o, rvalid_o, rd_data_o,
        input  mem_req_o, mem_addr_o, mem_wr_o, mem_wr_data_o,
        input  mem_byte_en_o, mem_zero_extnd_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Lets NUM_PORTS requesters (port 0 = instruction fetch, port 1 = data, ...)
// share one fixed-latency memory. At most one request is forwarded per cycle;
// each response is routed back to the port that issued it, in issue order.
//
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : mem_arbiter_if.slave, carrying the per-port request fields,
//              one-hot gnt_o / rvalid_o, shared rd_data_o, and the single
//              downstream memory request / response channel
//
// Parameters:
//   NUM_PORTS   : number of requester ports (>= 2)
//   ADDR_W      : address width
//   DATA_W      : data width
//   MEM_LATENCY : cycles from accepted memory request to valid read data (>= 1)
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN : when defined, lowest port index always wins and
//                           the round-robin pointer does not exist. Default
//                           (undefined) is round-robin arbitration.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0] win_idx;
    logic             win_found;
    logic             transfer;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest requesting index is the last
    // assignment and therefore wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.req_i[PTR_W'(i)]) begin
                win_idx   = PTR_W'(i);
                win_found = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] ptr;
    int unsigned      cand;

    // Search ptr, ptr+1, ... wrapping at NUM_PORTS-1 -> 0. The explicit
    // wrap keeps this correct for port counts that are not powers of two.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!win_found && bus.req_i[PTR_W'(cand)]) begin
                win_idx   = PTR_W'(cand);
                win_found = 1'b1;
            end
        end
    end

    // Pointer moves just past the port that was actually served; a stalled
    // memory leaves it untouched so the same winner is retried.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (transfer) begin
            if (int'(win_idx) == NUM_PORTS - 1) begin
                ptr <= '0;
            end else begin
                ptr <= win_idx + 1'b1;
            end
        end
    end
`endif

    assign transfer      = win_found && bus.mem_ready_i;
    assign bus.mem_req_o = |bus.req_i;

    // Downstream fields mirror the winner; they are forced to zero when
    // nobody requests so the memory never sees stale addresses.
    always_comb begin
        bus.gnt_o            = '0;
        bus.mem_addr_o       = '0;
        bus.mem_wr_o         = 1'b0;
        bus.mem_wr_data_o    = '0;
        bus.mem_byte_en_o    = 2'b00;
        bus.mem_zero_extnd_o = 1'b0;
        if (transfer) begin
            bus.gnt_o[win_idx] = 1'b1;
        end
        if (win_found) begin
            bus.mem_addr_o       = bus.addr_i[win_idx];
            bus.mem_wr_o         = bus.wr_i[win_idx];
            bus.mem_wr_data_o    = bus.wr_data_i[win_idx];
            bus.mem_byte_en_o    = bus.byte_en_i[win_idx];
            bus.mem_zero_extnd_o = bus.zero_extnd_i[win_idx];
        end
    end

    // Response tracking: one stage per cycle of memory latency. Stage 0 is
    // loaded on the granting edge, so the last stage lines up with the cycle
    // the memory presents read data.
    logic             pipe_valid [MEM_LATENCY];
    logic [PTR_W-1:0] pipe_id    [MEM_LATENCY];
    logic             pipe_wr    [MEM_LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_id[i]    <= '0;
                pipe_wr[i]    <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= transfer;
            pipe_id[0]    <= win_idx;
            pipe_wr[0]    <= bus.wr_i[win_idx];
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
                pipe_wr[i]    <= pipe_wr[i-1];
            end
        end
    end

    // Writes are acknowledged with zero data; whatever the memory drives on
    // its read bus during a write slot is ignored.
    always_comb begin
        bus.rvalid_o  = '0;
        bus.rd_data_o = '0;
        if (pipe_valid[MEM_LATENCY-1]) begin
            bus.rvalid_o[pipe_id[MEM_LATENCY-1]] = 1'b1;
            if (!pipe_wr[MEM_LATENCY-1]) begin
                bus.rd_data_o = bus.mem_rd_data_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter with four ports and a two-cycle memory.
// The bench plays both the requesters and the memory. A reference model
// (pending-request table, pointer, in-order response queue) predicts grants,
// downstream fields and responses every cycle; directed steps cover reset,
// contention, read return, write ack and backpressure, followed by a random
// phase.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NUM_PORTS   = 4;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int MEM_LATENCY = 2;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .NUM_PORTS   (NUM_PORTS),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MEM_LATENCY (MEM_LATENCY)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        int          due;
        int          port;
        bit          wr;
        logic [31:0] data;
    } resp_t;

    resp_t       rq[$];
    bit          pend    [NUM_PORTS];
    logic [31:0] f_addr  [NUM_PORTS];
    bit          f_wr    [NUM_PORTS];
    logic [31:0] f_wdata [NUM_PORTS];
    logic [1:0]  f_be    [NUM_PORTS];
    bit          f_ze    [NUM_PORTS];

    int          ptr_m     = 0;
    int          cyc       = 0;
    int          checks    = 0;
    int          errors    = 0;
    bit          in_reset  = 1'b1;
    bit          auto_gen  = 1'b0;
    int          req_pct   = 50;
    bit          ready_v   = 1'b1;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_data = 32'h0;

    logic [3:0]  obs_gnt;
    logic [3:0]  obs_rvalid;
    logic [31:0] obs_rd;
    logic        obs_mem_wr;
    logic [1:0]  obs_be;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_req(input int p, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] be, input bit ze);
        pend[p]    = 1'b1;
        f_wr[p]    = wr;
        f_addr[p]  = addr;
        f_wdata[p] = wd;
        f_be[p]    = be;
        f_ze[p]    = ze;
    endtask

    task automatic clear_reqs();
        for (int p = 0; p < NUM_PORTS; p++) pend[p] = 1'b0;
    endtask

    // Drive requester and memory inputs half a cycle before the active edge.
    task automatic apply_stimulus();
        @(negedge clk);
        if (auto_gen) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!pend[p] && ($urandom_range(0, 99) < req_pct)) begin
                    set_req(p, 1'($urandom_range(0, 1)), $urandom, $urandom,
                            2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                end
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.req_i[p]        = pend[p];
            bus.addr_i[p]       = f_addr[p];
            bus.wr_i[p]         = f_wr[p];
            bus.wr_data_i[p]    = f_wdata[p];
            bus.byte_en_i[p]    = f_be[p];
            bus.zero_extnd_i[p] = f_ze[p];
        end
        bus.mem_ready_i = ready_v;
        if (rq.size() > 0 && rq[0].due == cyc && !rq[0].wr) begin
            bus.mem_rd_data_i = rq[0].data;
        end else begin
            bus.mem_rd_data_i = $urandom;
        end
    endtask

    // Predict this cycle from the model, compare, then advance the model as
    // the coming clock edge will.
    task automatic check_output();
        int          win;
        bit          found;
        bit          any_req;
        bit          xfer;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_rvalid;
        logic [31:0] exp_rd;
        resp_t       r;

        #1;
        win     = 0;
        found   = 1'b0;
        any_req = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            int p = k;
`else
            int p = (ptr_m + k) % NUM_PORTS;
`endif
            if (pend[p]) any_req = 1'b1;
            if (pend[p] && !found) begin
                win   = p;
                found = 1'b1;
            end
        end
        xfer    = found && ready_v;
        exp_gnt = xfer ? 4'(1 << win) : 4'b0000;

        exp_rvalid = 4'b0000;
        exp_rd     = 32'h0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_rvalid = 4'(1 << rq[0].port);
            exp_rd     = rq[0].wr ? 32'h0 : rq[0].data;
        end

        chk("gnt_o",            64'(bus.gnt_o),            64'(exp_gnt));
        chk("mem_req_o",        64'(bus.mem_req_o),        64'(any_req));
        chk("mem_addr_o",       64'(bus.mem_addr_o),       found ? 64'(f_addr[win])  : 64'h0);
        chk("mem_wr_o",         64'(bus.mem_wr_o),         found ? 64'(f_wr[win])    : 64'h0);
        chk("mem_wr_data_o",    64'(bus.mem_wr_data_o),    found ? 64'(f_wdata[win]) : 64'h0);
        chk("mem_byte_en_o",    64'(bus.mem_byte_en_o),    found ? 64'(f_be[win])    : 64'h0);
        chk("mem_zero_extnd_o", 64'(bus.mem_zero_extnd_o), found ? 64'(f_ze[win])    : 64'h0);
        chk("rvalid_o",         64'(bus.rvalid_o),         64'(exp_rvalid));
        chk("rd_data_o",        64'(bus.rd_data_o),        64'(exp_rd));

        obs_gnt    = bus.gnt_o;
        obs_rvalid = bus.rvalid_o;
        obs_rd     = bus.rd_data_o;
        obs_mem_wr = bus.mem_wr_o;
        obs_be     = bus.mem_byte_en_o;

        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
        if (!in_reset && xfer) begin
            r.due  = cyc + MEM_LATENCY;
            r.port = win;
            r.wr   = f_wr[win];
            r.data = use_fixed ? fixed_data : $urandom;
            rq.push_back(r);
            ptr_m     = (win + 1) % NUM_PORTS;
            pend[win] = 1'b0;
        end
        cyc++;
    endtask

    task automatic step();
        apply_stimulus();
        check_output();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n  = 1'b0;
        in_reset = 1'b1;
        clear_reqs();
        bus.req_i = '0;
        rq.delete();
        ptr_m = 0;
        #1;
        chk("reset_rvalid",  64'(bus.rvalid_o),  64'h0);
        chk("reset_rd_data", 64'(bus.rd_data_o), 64'h0);
        cyc++;
        repeat (n) step();
        reset_n  = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic all_request();
        for (int p = 0; p < NUM_PORTS; p++) begin
            set_req(p, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
    endtask

    logic [3:0] exp_seq [4];

    initial begin
        reset_n              = 1'b0;
        bus.req_i            = '0;
        bus.addr_i           = '0;
        bus.wr_i             = '0;
        bus.wr_data_i        = '0;
        bus.byte_en_i        = '0;
        bus.zero_extnd_i     = '0;
        bus.mem_ready_i      = 1'b1;
        bus.mem_rd_data_i    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pend[p] = 1'b0; f_addr[p] = '0; f_wr[p] = 1'b0;
            f_wdata[p] = '0; f_be[p] = 2'b00; f_ze[p] = 1'b0;
        end
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0001;
`else
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;
`endif

        $display("[TB] power-on reset");
        do_reset(2);

        $display("[TB] contention: every port requests every cycle");
        for (int k = 0; k < 4; k++) begin
            all_request();
            step();
            chk("contention_gnt", 64'(obs_gnt), 64'(exp_seq[k]));
        end
        clear_reqs();
        repeat (MEM_LATENCY + 1) step();

        $display("[TB] read return on port 1");
        use_fixed  = 1'b1;
        fixed_data = 32'hDEADBEEF;
        set_req(1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        step();
        chk("read_gnt", 64'(obs_gnt), 64'h2);
        for (int k = 1; k <= MEM_LATENCY; k++) begin
            step();
            chk("read_rvalid", 64'(obs_rvalid), (k == MEM_LATENCY) ? 64'h2 : 64'h0);
        end
        chk("read_data", 64'(obs_rd), 64'hDEADBEEF);
        use_fixed = 1'b0;

        $display("[TB] write ack on port 1");
        set_req(1, 1'b1, 32'h40, 32'h55AA, 2'b01, 1'b0);
        step();
        chk("write_mem_wr", 64'(obs_mem_wr), 64'h1);
        chk("write_be",     64'(obs_be),     64'h1);
        repeat (MEM_LATENCY) step();
        chk("write_rvalid", 64'(obs_rvalid), 64'h2);
        chk("write_rd",     64'(obs_rd),     64'h0);

        $display("[TB] backpressure on port 0");
        set_req(0, 1'b0, 32'h200, 32'h0, 2'b10, 1'b1);
        ready_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_stall_gnt", 64'(obs_gnt), 64'h0);
        end
        ready_v = 1'b1;
        step();
        chk("bp_release_gnt", 64'(obs_gnt), 64'h1);
        repeat (MEM_LATENCY + 1) step();

        $display("[TB] reset with a read outstanding");
        set_req(2, 1'b0, 32'h300, 32'h0, 2'b10, 1'b0);
        step();
        do_reset(2);
        for (int k = 0; k < MEM_LATENCY + 1; k++) begin
            step();
            chk("post_reset_rvalid", 64'(obs_rvalid), 64'h0);
        end
        all_request();
        step();
        chk("post_reset_first_gnt", 64'(obs_gnt), 64'h1);

        $display("[TB] pipelined full load");
        for (int k = 0; k < 12; k++) begin
            all_request();
            step();
        end
        clear_reqs();

        $display("[TB] random traffic");
        auto_gen = 1'b1;
        for (int k = 0; k < 400; k++) begin
            ready_v = ($urandom_range(0, 99) < 70);
            req_pct = int'($urandom_range(20, 90));
            step();
        end

        auto_gen = 1'b0;
        ready_v  = 1'b1;
        for (int k = 0; k < 50; k++) begin
            bit busy;
            busy = (rq.size() > 0);
            for (int p = 0; p < NUM_PORTS; p++) if (pend[p]) busy = 1'b1;
            if (!busy) break;
            step();
        end
        begin
            int left;
            left = rq.size();
            for (int p = 0; p < NUM_PORTS; p++) if (pend[p]) left++;
            chk("drain_complete", 64'(left), 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
